// File: rtl/dlfloat_mac_seq_if.sv
// rtl/dlfloat_mac_seq_if.sv - operand stream, MAC and result stream signals of the dot-product sequencer
interface dlfloat_mac_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_issue;
  logic        mac_clr;
  logic [15:0] mac_res;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  // sequencer side
  modport slave (
    input  in_valid, in_a, in_b, mac_res, out_ready,
    output in_ready, mac_a, mac_b, mac_issue, mac_clr, out_valid, out_data
  );

  // operand source, MAC and result consumer side
  modport master (
    output in_valid, in_a, in_b, mac_res, out_ready,
    input  in_ready, mac_a, mac_b, mac_issue, mac_clr, out_valid, out_data
  );
endinterface

// File: rtl/dlfloat_mac_seq.sv
// rtl/dlfloat_mac_seq.sv - length-N DLFloat dot-product sequencer for dlfloat_mac (option: DLF_SEQ_ZERO_SKIP_EN)
module dlfloat_mac_seq #(
  parameter int MAC_LAT = 3,
  parameter int LEN_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
  dlfloat_mac_seq_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   drain_q;
  logic [15:0]        mac_a_q;
  logic [15:0]        mac_b_q;
  logic               mac_issue_q;
  logic               mac_clr_q;
  logic [15:0]        out_data_q;
  logic               done_q;

  logic               accept;
  logic               xfer;
  logic               issue_en;
  logic               last_xfer;
  logic               drain_end;

  assign accept    = (state_q == IDLE) && start;
  assign xfer      = (state_q == LOAD) && bus.in_valid;
  assign last_xfer = xfer && (rem_q == LEN_W'(1));
  assign drain_end = (state_q == DRAIN) && (drain_q <= LEN_W'(1));

`ifdef DLF_SEQ_ZERO_SKIP_EN
  // A zero operand contributes nothing to the sum, so the pair is consumed without disturbing the adder
  assign issue_en = xfer && (bus.in_a != 16'h0000) && (bus.in_b != 16'h0000);
`else
  assign issue_en = xfer;
`endif

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_issue = mac_issue_q;
  assign bus.mac_clr   = mac_clr_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection: empty jobs skip straight to HOLD, the last pair starts the drain
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? HOLD : LOAD;
        end
      end
      LOAD: begin
        if (last_xfer) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_end) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, registered MAC controls and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      drain_q     <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_issue_q <= 1'b0;
      mac_clr_q   <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      mac_clr_q   <= accept;
      mac_issue_q <= issue_en;
      done_q      <= (state_q == HOLD) && bus.out_ready;

      if (issue_en) begin
        mac_a_q <= bus.in_a;
        mac_b_q <= bus.in_b;
      end

      if (accept) begin
        rem_q <= len;
      end else if (xfer && (rem_q != '0)) begin
        rem_q <= rem_q - LEN_W'(1);
      end

      if (last_xfer) begin
        drain_q <= LEN_W'(MAC_LAT);
      end else if ((state_q == DRAIN) && (drain_q != '0)) begin
        drain_q <= drain_q - LEN_W'(1);
      end

      if (accept && (len == '0)) begin
        out_data_q <= 16'h0000;
      end else if (drain_end) begin
        out_data_q <= bus.mac_res;
      end
    end
  end

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// tb/tb_dlfloat_mac_seq.sv - directed vector bench for dlfloat_mac_seq with a behavioural MAC
module tb_dlfloat_mac_seq;
  localparam int MAC_LAT = 3;
  localparam int LEN_W   = 8;

  typedef struct {
    int                n;
    logic [7:0][15:0]  a;
    logic [7:0][15:0]  b;
    int                gap_at;
    int                gap_len;
    logic [15:0]       exp_res;
    int                exp_iss;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             done;
  int               cyc = 0;
  int               issue_total = 0;
  int               checks = 0;
  int               failures = 0;
  logic [15:0]      res1;
  vec_t             vecs[5];

  dlfloat_mac_seq_if bus ();

  dlfloat_mac_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mac_issue) issue_total <= issue_total + 1;

  function automatic real dlf2real(input logic [15:0] x);
    real v;
    int  e;
    if (x[14:9] == 6'd0) return 0.0;
    v = 1.0 + real'(int'(x[8:0])) / 512.0;
    e = int'(x[14:9]) - 31;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real2dlf(input real r);
    real v;
    int  e;
    int  m;
    if (r <= 0.0) return 16'h0000;
    v = r;
    e = 31;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    m = $rtoi((v - 1.0) * 512.0 + 0.5);
    return {1'b0, 6'(e), 9'(m)};
  endfunction

  // Behavioural MAC: last issue in cycle I is visible on mac_res in cycle I+MAC_LAT-1
  always @(posedge clk or negedge rst_n) begin : mac_model
    real acc;
    if (!rst_n) begin
      acc = 0.0;
      res1 <= 16'h0000;
      bus.mac_res <= 16'h0000;
    end else begin
      if (bus.mac_clr) acc = 0.0;
      else if (bus.mac_issue) acc = acc + dlf2real(bus.mac_a) * dlf2real(bus.mac_b);
      res1 <= real2dlf(acc);
      bus.mac_res <= res1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".busy"},  {31'd0, busy}, 0);
    check({tag, ".outs"},
          {busy, bus.in_ready, bus.mac_issue, bus.mac_clr, bus.out_valid, done, 26'd0}, 0);
    check({tag, ".mac_ab"}, {bus.mac_a, bus.mac_b}, 0);
    check({tag, ".out_data"}, {16'd0, bus.out_data}, 0);
  endtask

  task automatic run_job(input int n, input logic [7:0][15:0] a, input logic [7:0][15:0] b,
                         input int gap_at, input int gap_len, input logic [15:0] exp_res,
                         input int exp_iss, input int bp, input string tag);
    int s;
    int tl;
    int iss0;
    int w;
    bit stable;
    iss0 = issue_total;
    start = 1'b1;
    len = LEN_W'(n);
    s = cyc;
    tl = s;
    tick();
    start = 1'b0;
    check({tag, ".clr"}, {31'd0, bus.mac_clr}, 1);
    check({tag, ".busy"}, {31'd0, busy}, 1);
    for (int i = 0; i < n; i++) begin
      if (i == 0) check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 1);
      bus.in_valid = 1'b1;
      bus.in_a = a[i];
      bus.in_b = b[i];
      tl = cyc;
      tick();
      if (i == gap_at) begin
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check($sformatf("%s.gap_issue%0d", tag, g), {31'd0, bus.mac_issue}, 0);
        end
      end
    end
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      tick();
      w++;
    end
    check({tag, ".latency"}, cyc - tl, (n > 0) ? MAC_LAT + 1 : 1);
    check({tag, ".out_data"}, {16'd0, bus.out_data}, {16'd0, exp_res});
    stable = 1'b1;
    for (int k = 0; k < bp; k++) begin
      bus.out_ready = 1'b0;
      start = 1'b1;
      len = '0;
      tick();
      if (!(bus.out_valid && busy && bus.out_data == exp_res)) stable = 1'b0;
    end
    start = 1'b0;
    if (bp > 0) check({tag, ".hold_stable"}, {31'd0, stable}, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".done"}, {31'd0, done}, 1);
    check({tag, ".idle"}, {30'd0, busy, bus.out_valid}, 0);
    check({tag, ".issues"}, issue_total - iss0, exp_iss);
    tick();
    check({tag, ".done_pulse"}, {30'd0, done, busy}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      vecs[i].a = '0;
      vecs[i].b = '0;
      vecs[i].gap_at = -1;
      vecs[i].gap_len = 0;
    end
    // 1.0 x 1.0
    vecs[0].n = 1; vecs[0].a[0] = 16'h3E00; vecs[0].b[0] = 16'h3E00;
    vecs[0].exp_res = 16'h3E00; vecs[0].exp_iss = 1;
    // 4 x (1.0 x 2.0) = 8.0 with a 2-cycle gap after the 2nd pair
    vecs[1].n = 4;
    for (int k = 0; k < 4; k++) begin vecs[1].a[k] = 16'h3E00; vecs[1].b[k] = 16'h4000; end
    vecs[1].gap_at = 1; vecs[1].gap_len = 2;
    vecs[1].exp_res = 16'h4400; vecs[1].exp_iss = 4;
    // 1.0 x 2.0 + 2.0 x 2.0 = 6.0
    vecs[2].n = 2;
    vecs[2].a[0] = 16'h3E00; vecs[2].b[0] = 16'h4000;
    vecs[2].a[1] = 16'h4000; vecs[2].b[1] = 16'h4000;
    vecs[2].exp_res = 16'h4300; vecs[2].exp_iss = 2;
    // zero operands: 0 + 1.0 + 0 = 1.0
    vecs[3].n = 3;
    vecs[3].a[0] = 16'h0000; vecs[3].b[0] = 16'h3E00;
    vecs[3].a[1] = 16'h3E00; vecs[3].b[1] = 16'h3E00;
    vecs[3].a[2] = 16'h3E00; vecs[3].b[2] = 16'h0000;
    vecs[3].exp_res = 16'h3E00;
`ifdef DLF_SEQ_ZERO_SKIP_EN
    vecs[3].exp_iss = 1;
`else
    vecs[3].exp_iss = 3;
`endif
    // empty job
    vecs[4].n = 0; vecs[4].exp_res = 16'h0000; vecs[4].exp_iss = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].gap_at, vecs[i].gap_len,
              vecs[i].exp_res, vecs[i].exp_iss, 0, $sformatf("vec%0d", i));
    end

    // result held under backpressure while extra starts are ignored
    run_job(1, vecs[2].a, vecs[2].b, -1, 0, 16'h4000, 1, 5, "bp");

    // new job accepted in the same cycle done is high
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    check("b2b.valid1", {31'd0, bus.out_valid}, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    start = 1'b1; len = '0;
    check("b2b.done1", {31'd0, done}, 1);
    tick();
    start = 1'b0;
    check("b2b.valid2", {30'd0, bus.out_valid, bus.mac_clr}, 3);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("b2b.done2", {31'd0, done}, 1);
    tick();

    // reset during LOAD after 2 of 6 pairs
    start = 1'b1; len = 8'd6;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1; bus.in_a = 16'h4000; bus.in_b = 16'h4000;
      tick();
    end
    bus.in_valid = 1'b0;
    check("midrst.issue_before", {31'd0, bus.mac_issue}, 1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    check_reset("midrst.after");
    run_job(1, vecs[0].a, vecs[0].b, -1, 0, 16'h3E00, 1, 0, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dlfloat_mac_seq.md
# dlfloat_mac_seq

Sequencer that feeds the 16-bit DLFloat multiply-accumulate datapath a length-N dot product and returns the accumulated result. It accepts operand pairs over a valid/ready stream, issues one pair per cycle to the MAC, waits out the fixed MAC pipeline latency after the last issue, then holds the result on an output valid/ready port. It sits between the chip-level I/O register wrapper and `dlfloat_mac`, replacing the free-running two-cycle operand loader.

## Interface

- `MAC_LAT`, default 3: cycles from a `mac_issue` cycle to its contribution appearing on `mac_res`. Must be ≥ 1.
- `LEN_W`, default 8: width of the job length field.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request, sampled only in IDLE.
- `len` in LEN_W: number of operand pairs, sampled with `start`.
- `busy` out 1: high in any state other than IDLE.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can take a pair.
- `in_a`, `in_b` in 16 each: DLFloat operands.
- `mac_a`, `mac_b` out 16 each: registered operands to the MAC.
- `mac_issue` out 1: registered; high for one cycle per operand pair issued.
- `mac_clr` out 1: registered one-cycle pulse that clears the MAC accumulator.
- `mac_res` in 16: accumulator output from the MAC.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 16: registered result.
- `done` out 1: one-cycle pulse on result handshake.

## Operation

- States: IDLE, LOAD, DRAIN, HOLD.
- **IDLE:**
  - On `start`, latch `len` into the remaining-count register and pulse `mac_clr` on the next cycle.
  - If `len` == 0, go to HOLD with `out_data` = 16'h0000.
  - Otherwise go to LOAD.
- **LOAD:**
  - `in_ready` = 1.
  - A pair transfers when `in_valid & in_ready`. On transfer, register `in_a`/`in_b` into `mac_a`/`mac_b`, assert `mac_issue` the next cycle, and decrement the remaining count.
  - The transfer that takes the count to 0 moves the state to DRAIN and loads the drain counter with `MAC_LAT`.
  - An `in_valid` gap holds LOAD with no issue. There is no timeout.
- **DRAIN:**
  - `in_ready` = 0.
  - The drain counter decrements each cycle.
  - When it reaches 1, capture `mac_res` into `out_data` on that edge and go to HOLD.
- **HOLD:**
  - `out_valid` = 1, and `out_data` is stable.
  - On `out_valid & out_ready`, pulse `done` and return to IDLE.
- `start` outside IDLE is ignored.
- `mac_a`/`mac_b` keep their last value when not issuing.
- Counters are unsigned LEN_W bits, and the full range up to 2^LEN_W−1 is supported. Decrements never wrap: count 0 is never decremented.

## Timing

- Reset values: `busy`=0, `in_ready`=0, `mac_issue`=0, `mac_clr`=0, `mac_a`=`mac_b`=0, `out_valid`=0, `out_data`=0, `done`=0. State resets to IDLE and both counters to 0.
- Job start:
  - `start` high in cycle S.
  - `mac_clr` and `busy` are high from S+1.
  - `in_ready` is high from S+1.
- Issue timing and throughput:
  - A transfer in cycle T gives `mac_issue` in T+1.
  - Throughput is one pair per cycle.
- Result timing:
  - If the last transfer is at T_L, DRAIN occupies T_L+1 … T_L+MAC_LAT.
  - `out_valid` is high from T_L+MAC_LAT+1.
- Zero-length job: `start` in S gives `out_valid` in S+1 and `mac_clr` in S+1.
- `done` is high in the cycle after the result handshake. `start` is accepted in the same cycle that `done` is high.
- Reset mid-job: asserting `rst_n`=0 in any state immediately forces all reset values, and no partial result is emitted.

## Configuration

- `DLF_SEQ_ZERO_SKIP_EN` defined:
  - In LOAD, a pair with `in_a`==0 or `in_b`==0 is accepted and decrements the count, but `mac_issue` stays low.
  - This matches the multiplier's zero-product rule and saves adder activity.
  - If the final pair is skipped, DRAIN still lasts `MAC_LAT` cycles.
- `DLF_SEQ_ZERO_SKIP_EN` undefined: every accepted pair is issued.

## Test plan

- **Single pair:**
  - Stimulus: reset, then `start`, `len`=1, pair 0x3E00×0x3E00 (1.0×1.0), with a behavioural MAC (`MAC_LAT`=3).
  - Required: `mac_clr` at S+1, `mac_issue` once, `out_valid` at T_L+4, `out_data`=0x3E00, `done` one cycle after the handshake.
- **Burst with gaps:**
  - Stimulus: `len`=4, pairs 0x3E00×0x4000, `in_valid` low for 2 cycles after the 2nd pair.
  - Required: exactly 4 `mac_issue` pulses, no issue during the gap, and the result equals the model's value.
- **Zero length:**
  - Stimulus: `start` with `len`=0.
  - Required: `out_valid` at S+1, `out_data`=0x0000, no `mac_issue`.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 5 cycles in HOLD.
  - Required: `out_valid`, `out_data` and `busy` stay stable, and a second `start` is ignored until after the handshake.
- **Reset mid-job:**
  - Stimulus: `rst_n` low during LOAD with 2 of `len`=6 pairs accepted.
  - Required: all outputs are at reset values in the same cycle, and a new `len`=1 job then completes normally.
- **Zero skip:**
  - Stimulus: with `DLF_SEQ_ZERO_SKIP_EN` defined, `len`=3, pairs (0x0000, 0x3E00), (0x3E00, 0x3E00), (0x3E00, 0x0000).
  - Required: exactly 1 `mac_issue`, and `out_valid` at T_L+4 counted from the 3rd transfer.
